blockmem_port_arb: RTL and testbench
====================================

// Module: blockmem_port_arb
// PURPOSE
//  Shares one port of the dual-port block RAM (1-cycle registered read) between two requesters.
//  - Round-robin arbitration between requester 0 and requester 1.
//  - Routes read data back to the requester that issued the read.
//  - Built-in clear sequencer zero-fills the whole RAM on command and locks out requesters while it runs.
//  - Sits between register/bus logic and one RAM port (clk/en/we/addr/din/dout).
// PARAMETERS
//  G_MEMWIDTH   32     data width in bits; must be a multiple of 8
//  G_MEMDEPTH   1024   words in the RAM
//  G_ADDRWIDTH  -      localparam, $clog2(G_MEMDEPTH)
//  G_WEWIDTH    -      localparam, ((G_MEMWIDTH-1)/8)+1 byte enables
// PORTS
//  clk        in   1            single clock, all logic on rising edge
//  rst        in   1            asynchronous reset, active-high
//  req0/req1  in   1            requester k access request; held until ack k
//  we0/we1    in   G_WEWIDTH    byte write enables; all-zero means read
//  addr0/1    in   G_ADDRWIDTH  word address
//  wdata0/1   in   G_MEMWIDTH   write data
//  ack0/ack1  out  1            access accepted this cycle (combinational)
//  rvalid0/1  out  1            read data valid for requester k
//  rdata0/1   out  G_MEMWIDTH   read data; meaningful only when rvalid k is high
//  clr_start  in   1            pulse: start zero-fill of the whole RAM
//  clr_busy   out  1            zero-fill in progress
//  clr_done   out  1            one-cycle pulse, zero-fill completed
//  mem_en     out  1            RAM port enable
//  mem_we     out  G_WEWIDTH    RAM byte write enables
//  mem_addr   out  G_ADDRWIDTH  RAM address
//  mem_din    out  G_MEMWIDTH   RAM write data
//  mem_dout   in   G_MEMWIDTH   RAM read data, registered by the RAM, valid 1 cycle after en
// BEHAVIOUR
//  Reset values:
//  - Registered outputs (rvalid*, clr_busy, clr_done) reset to 0.
//  - While rst is high, ack* and mem_en are forced to 0.
//  - Round-robin pointer resets to last=1, so requester 0 wins the first tie.
//  - FSM resets to IDLE; clear counter resets to 0.
//  FSM states:
//  - IDLE -> CLEAR on clr_start. CLEAR -> IDLE after the write to address G_MEMDEPTH-1.
//  - clr_start is ignored while in CLEAR.
//  IDLE arbitration (combinational):
//  - Only req0 high: ack0=1. Only req1 high: ack1=1.
//  - Both high: grant the requester that did not win last; last updates on every grant.
//  - At most one ack per cycle.
//  - mem_en=1 and mem_we/addr/din come from the granted requester; no grant -> mem_en=0, mem_we=0.
//  Read latency:
//  - A read (we==0) acked in cycle N gives rvalid k=1 in cycle N+1, with rdata k = mem_dout.
//  - Writes never raise rvalid.
//  - Back-to-back reads give one rvalid per cycle; no bubbles.
//  - rdata0 and rdata1 are wired directly to mem_dout.
//  CLEAR:
//  - Each cycle: mem_en=1, mem_we=all ones, mem_din=0, mem_addr=counter; counter increments.
//  - Takes exactly G_MEMDEPTH cycles; ack0=ack1=0 throughout.
//  - clr_busy=1 from the cycle after clr_start until the cycle after the last write.
//  - clr_done pulses in the cycle the FSM returns to IDLE.
//  - Requests pending during CLEAR are served after it; round-robin state is kept.
//  Boundary conditions:
//  - clr_start and a req in the same IDLE cycle: the req is acked that cycle; CLEAR starts next cycle.
//  - A read acked just before CLEAR still returns rvalid on the next cycle.
//  - Counter terminates on G_MEMDEPTH-1 and must not wrap, even when G_MEMDEPTH is not a power of 2.
//  - rst mid-CLEAR: back to IDLE immediately, RAM partially cleared, no clr_done.
//  - rst with a read outstanding: rvalid is dropped.
// TESTING
//  1. req0 write addr 5 = 0xDEADBEEF, we=0xF; then req0 read addr 5 -> ack0 on first cycle;
//     rvalid0=1 and rdata0=0xDEADBEEF exactly 1 cycle after the read ack.
//  2. req0 and req1 both held reading addr 1 and addr 2 for 4 cycles -> acks alternate 0,1,0,1.
//     Each rvalid lands only on its own requester, 1 cycle later, with matching data.
//  3. Write 0xAABBCCDD then write we=0x2 data 0x00001100 -> readback 0xAABB11DD.
//  4. clr_start with G_MEMDEPTH=16 -> clr_busy high 16 cycles, mem_addr 0..15, clr_done once.
//     req1 held during the clear gets ack1 only after the clear; readback of any address is 0.
//  5. Assert rst at clear address 7 -> clr_busy=0, no clr_done.
//     Address 8 keeps its old value; a new clr_start clears from address 0.
//  6. Read ack in the same cycle as clr_start -> rvalid next cycle with the pre-clear data.

Source files
------------

// File: rtl/blockmem_port_arb_if.sv
// Requester-side bus of the block RAM port arbiter: request/ack handshake,
// write data, and the read-return channel.
interface blockmem_port_arb_if #(
  parameter int G_MEMWIDTH = 32,
  parameter int G_MEMDEPTH = 1024
);
  localparam int G_ADDRWIDTH = (G_MEMDEPTH > 1) ? $clog2(G_MEMDEPTH) : 1;
  localparam int G_WEWIDTH   = ((G_MEMWIDTH - 1) / 8) + 1;

  logic                   req;
  logic [G_WEWIDTH-1:0]   we;
  logic [G_ADDRWIDTH-1:0] addr;
  logic [G_MEMWIDTH-1:0]  wdata;
  logic                   ack;
  logic                   rvalid;
  logic [G_MEMWIDTH-1:0]  rdata;

  modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/blockmem_port_arb.sv
// Round-robin sharing of one block RAM port between two requesters, with a
// built-in zero-fill sequencer that locks requesters out while it runs.
module blockmem_port_arb_lane #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic rvalid
);
  logic [RD_LAT-1:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
      vld_pipe[0] <= issue;
    end
  end

  assign rvalid = vld_pipe[RD_LAT-1];
endmodule

module blockmem_port_arb #(
  parameter  int G_MEMWIDTH  = 32,
  parameter  int G_MEMDEPTH  = 1024,
  localparam int G_ADDRWIDTH = (G_MEMDEPTH > 1) ? $clog2(G_MEMDEPTH) : 1,
  localparam int G_WEWIDTH   = ((G_MEMWIDTH - 1) / 8) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  blockmem_port_arb_if.slave     rq0,
  blockmem_port_arb_if.slave     rq1,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic                   mem_en,
  output logic [G_WEWIDTH-1:0]   mem_we,
  output logic [G_ADDRWIDTH-1:0] mem_addr,
  output logic [G_MEMWIDTH-1:0]  mem_din,
  input  logic [G_MEMWIDTH-1:0]  mem_dout
);
  localparam int NUM_REQ = 2;
  localparam logic [G_ADDRWIDTH-1:0] LAST_ADDR = G_ADDRWIDTH'(G_MEMDEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                              state, state_nxt;
  logic [G_ADDRWIDTH-1:0]              cnt;
  logic                                last, last_nxt;
  logic [NUM_REQ-1:0]                  req, ack, rd, rvalid;
  logic [NUM_REQ-1:0][G_WEWIDTH-1:0]   we;
  logic [NUM_REQ-1:0][G_ADDRWIDTH-1:0] addr;
  logic [NUM_REQ-1:0][G_MEMWIDTH-1:0]  wdata;
  logic                                gsel;

  assign req   = {rq1.req, rq0.req};
  assign we    = {rq1.we, rq0.we};
  assign addr  = {rq1.addr, rq0.addr};
  assign wdata = {rq1.wdata, rq0.wdata};

  assign rq0.ack    = ack[0];
  assign rq1.ack    = ack[1];
  assign rq0.rvalid = rvalid[0];
  assign rq1.rvalid = rvalid[1];
  assign rq0.rdata  = mem_dout;
  assign rq1.rdata  = mem_dout;

  // last==1 means requester 1 won most recently, so requester 0 takes a tie.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    ack       = '0;
    gsel      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_din   = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req[0] && (!req[1] || last)) ack[0] = 1'b1;
          else if (req[1])                 ack[1] = 1'b1;
          if (|ack) begin
            gsel     = ack[1];
            mem_en   = 1'b1;
            mem_we   = we[gsel];
            mem_addr = addr[gsel];
            mem_din  = wdata[gsel];
            last_nxt = gsel;
          end
          if (clr_start) state_nxt = CLEAR;
        end
        CLEAR: begin
          mem_en   = 1'b1;
          mem_we   = '1;
          mem_addr = cnt;
          if (cnt == LAST_ADDR) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      clr_busy <= (state_nxt == CLEAR);
      clr_done <= (state == CLEAR) && (state_nxt == IDLE);
      // Explicit terminal compare keeps non-power-of-2 depths from wrapping.
      if (state == CLEAR && cnt != LAST_ADDR) cnt <= cnt + G_ADDRWIDTH'(1);
      else                                    cnt <= '0;
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign rd[k] = ack[k] && (we[k] == '0);
    blockmem_port_arb_lane #(.RD_LAT(1)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .issue  (rd[k]),
      .rvalid (rvalid[k])
    );
  end
endmodule

// File: tb/tb_blockmem_port_arb.sv
// Directed and random checks of blockmem_port_arb against a behavioural model
// with a small registered-read RAM attached to the memory port.
module tb_blockmem_port_arb;
  localparam int W   = 32;
  localparam int D   = 16;
  localparam int AW  = 4;
  localparam int WEW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_start, clr_busy, clr_done, mem_en;
  logic [WEW-1:0] mem_we;
  logic [AW-1:0]  mem_addr;
  logic [W-1:0]   mem_din, mem_dout;

  always #5 clk = ~clk;

  blockmem_port_arb_if #(.G_MEMWIDTH(W), .G_MEMDEPTH(D)) rq0 ();
  blockmem_port_arb_if #(.G_MEMWIDTH(W), .G_MEMDEPTH(D)) rq1 ();

  blockmem_port_arb #(.G_MEMWIDTH(W), .G_MEMDEPTH(D)) dut (
    .clk(clk), .rst(rst), .rq0(rq0), .rq1(rq1),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // RAM port: read-first, data registered one cycle after en
  logic [W-1:0] ram [D];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= ram[mem_addr];
      for (int b = 0; b < WEW; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  // behavioural model
  logic [W-1:0] ref_mem [D];
  int           m_clr;
  int           m_last;
  logic [1:0]   exp_rv;
  logic [W-1:0] exp_rd [2];
  logic         exp_done;
  logic [1:0]   ack_seen;
  int           g_seen;
  int           compared;
  int           mismatched;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                         input logic [WEW-1:0] be);
    logic [W-1:0] r;
    r = old;
    for (int b = 0; b < WEW; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic set_req(input int k, input logic on, input logic [WEW-1:0] we,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
    if (k == 0) begin
      rq0.req = on; rq0.we = we; rq0.addr = a; rq0.wdata = d;
    end else begin
      rq1.req = on; rq1.we = we; rq1.addr = a; rq1.wdata = d;
    end
  endtask

  task automatic model_reset();
    m_clr = 0; m_last = 1; exp_rv = '0; exp_done = 1'b0;
  endtask

  // One clock: combinational checks mid-cycle, model step at the edge, registered checks after.
  task automatic tick();
    int g;
    logic [WEW-1:0] gwe;
    logic [AW-1:0]  ga;
    logic [W-1:0]   gd;
    @(negedge clk);
    g = -1;
    if (m_clr == 0) begin
      if (rq0.req && rq1.req) g = (m_last == 1) ? 0 : 1;
      else if (rq0.req)       g = 0;
      else if (rq1.req)       g = 1;
    end
    chk("ack0", rq0.ack, W'(g == 0));
    chk("ack1", rq1.ack, W'(g == 1));
    chk("mem_en", mem_en, W'(g >= 0 || m_clr > 0));
    if (m_clr > 0) begin
      chk("clr_addr", mem_addr, W'(D - m_clr));
      chk("clr_we", mem_we, W'(4'hF));
      chk("clr_din", mem_din, '0);
    end
    gwe = (g == 1) ? rq1.we : rq0.we;
    ga  = (g == 1) ? rq1.addr : rq0.addr;
    gd  = (g == 1) ? rq1.wdata : rq0.wdata;
    if (g >= 0) chk("mem_addr", mem_addr, W'(ga));
    ack_seen = {g == 1, g == 0};
    g_seen   = g;
    @(posedge clk);
    exp_rv   = '0;
    exp_done = 1'b0;
    if (m_clr > 0) begin
      ref_mem[D - m_clr] = '0;
      m_clr--;
      exp_done = (m_clr == 0);
    end else begin
      if (g >= 0) begin
        if (gwe == '0) begin
          exp_rv[g] = 1'b1;
          exp_rd[g] = ref_mem[ga];
        end else begin
          ref_mem[ga] = merge(ref_mem[ga], gd, gwe);
        end
        m_last = g;
      end
      if (clr_start) m_clr = D;
    end
    #1;
    chk("rvalid0", rq0.rvalid, W'(exp_rv[0]));
    chk("rvalid1", rq1.rvalid, W'(exp_rv[1]));
    if (exp_rv[0]) chk("rdata0", rq0.rdata, exp_rd[0]);
    if (exp_rv[1]) chk("rdata1", rq1.rdata, exp_rd[1]);
    chk("clr_busy", clr_busy, W'(m_clr > 0));
    chk("clr_done", clr_done, W'(exp_done));
  endtask

  task automatic access(input int k, input logic [WEW-1:0] we, input logic [AW-1:0] a,
                        input logic [W-1:0] d, output int n);
    set_req(k, 1'b1, we, a, d);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack_seen[k] && n < 64);
    chk("ack_timeout", W'(ack_seen[k]), W'(1));
    set_req(k, 1'b0, '0, '0, '0);
  endtask

  task automatic run_clear_out();
    int n;
    n = 0;
    while (clr_busy && n < 3 * D) begin
      tick();
      n++;
    end
    chk("clear_timeout", W'(clr_busy), '0);
  endtask

  initial begin
    int n, busy_cnt, done_cnt;
    int ord [4];
    logic [W-1:0] v;
    compared = 0; mismatched = 0;
    for (int i = 0; i < D; i++) begin
      v = $urandom;
      ram[i] = v;
      ref_mem[i] = v;
    end
    model_reset();
    rst = 1'b1; clr_start = 1'b0;
    set_req(0, 1'b1, '0, 4'd3, '0);
    set_req(1, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", rq0.ack, '0);
    chk("rst_ack1", rq1.ack, '0);
    chk("rst_mem_en", mem_en, '0);
    chk("rst_rvalid0", rq0.rvalid, '0);
    chk("rst_rvalid1", rq1.rvalid, '0);
    chk("rst_busy", clr_busy, '0);
    chk("rst_done", clr_done, '0);
    set_req(0, 1'b0, '0, '0, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // write then read back on requester 0
    access(0, 4'hF, 4'd5, 32'hDEADBEEF, n);
    chk("t1_wr_lat", W'(n), W'(1));
    access(0, 4'h0, 4'd5, '0, n);
    chk("t1_rd_lat", W'(n), W'(1));
    chk("t1_rvalid0", rq0.rvalid, W'(1));
    chk("t1_rdata0", rq0.rdata, 32'hDEADBEEF);

    // tie-break alternation, requester 1 won last
    access(0, 4'hF, 4'd1, 32'h11110001, n);
    access(1, 4'hF, 4'd2, 32'h22220002, n);
    set_req(0, 1'b1, '0, 4'd1, '0);
    set_req(1, 1'b1, '0, 4'd2, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      ord[i] = g_seen;
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) chk("t2_order", W'(ord[i]), W'(i % 2));
    tick();
    chk("t2_last_rdata1", rq1.rvalid, '0);

    // byte-enable merge
    access(0, 4'hF, 4'd3, 32'hAABBCCDD, n);
    access(0, 4'h2, 4'd3, 32'h00001100, n);
    access(1, 4'h0, 4'd3, '0, n);
    chk("t3_rdata1", rq1.rdata, 32'hAABB11DD);

    // full clear with requester 1 held off
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    busy_cnt = clr_busy ? 1 : 0;
    done_cnt = 0;
    set_req(1, 1'b1, '0, 4'd3, '0);
    n = 0;
    do begin
      tick();
      n++;
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
    end while (!ack_seen[1] && n < 40);
    set_req(1, 1'b0, '0, '0, '0);
    chk("t4_busy_cycles", W'(busy_cnt), W'(D));
    chk("t4_done_pulses", W'(done_cnt), W'(1));
    chk("t4_ack1_wait", W'(n), W'(D + 1));
    chk("t4_rdata1_zero", rq1.rdata, '0);

    // read acked in the clr_start cycle returns pre-clear data
    access(0, 4'hF, 4'd4, 32'h55AA55AA, n);
    set_req(0, 1'b1, '0, 4'd4, '0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    set_req(0, 1'b0, '0, '0, '0);
    chk("t6_ack0", W'(ack_seen[0]), W'(1));
    chk("t6_rvalid0", rq0.rvalid, W'(1));
    chk("t6_rdata0", rq0.rdata, 32'h55AA55AA);
    run_clear_out();

    // reset in the middle of a clear
    access(0, 4'hF, 4'd7, 32'h77777777, n);
    access(1, 4'hF, 4'd8, 32'h88888888, n);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (7) tick();
    @(negedge clk);
    chk("t5_addr7", mem_addr, W'(7));
    rst = 1'b1;
    #1;
    chk("t5_busy", clr_busy, '0);
    chk("t5_mem_en", mem_en, '0);
    model_reset();
    @(posedge clk); #1;
    chk("t5_done", clr_done, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_done_after", clr_done, '0);
    access(0, 4'h0, 4'd8, '0, n);
    chk("t5_addr8_kept", rq0.rdata, 32'h88888888);
    access(0, 4'h0, 4'd7, '0, n);
    chk("t5_addr7_kept", rq0.rdata, 32'h77777777);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    @(negedge clk);
    chk("t5_restart_addr", mem_addr, '0);
    @(posedge clk); #1;
    ref_mem[0] = '0;
    m_clr--;
    run_clear_out();

    // reset with a read outstanding drops rvalid
    set_req(1, 1'b1, '0, 4'd9, '0);
    @(negedge clk);
    chk("rst_rd_ack1", rq1.ack, W'(1));
    rst = 1'b1;
    #1;
    chk("rst_rd_ack_forced", rq1.ack, '0);
    model_reset();
    @(posedge clk); #1;
    chk("rst_rd_rvalid1", rq1.rvalid, '0);
    set_req(1, 1'b0, '0, '0, '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // random traffic with occasional clears
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!((k == 0) ? rq0.req : rq1.req) && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1) set_req(k, 1'b1, '0, AW'($urandom_range(0, D-1)), '0);
          else set_req(k, 1'b1, WEW'($urandom_range(1, 15)), AW'($urandom_range(0, D-1)), $urandom);
        end
      end
      clr_start = ($urandom_range(0, 79) == 0);
      tick();
      clr_start = 1'b0;
      if (ack_seen[0]) set_req(0, 1'b0, '0, '0, '0);
      if (ack_seen[1]) set_req(1, 1'b0, '0, '0, '0);
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    run_clear_out();
    for (int a = 0; a < D; a++) begin
      access(a % 2, '0, AW'(a), '0, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
